// File: rtl/cook_timer_counter.sv
// MM:SS cook timer: keypad digit entry, tick-driven BCD countdown, done hold.
// Optional COOK_TIMER_NORMALIZE_EN folds seconds-tens 6..9 into minutes on start.
`timescale 1ns/1ps
module cook_timer_counter #(
   parameter logic [3:0] SEC_TENS_WRAP   = 4'd5,
   parameter logic [3:0] DONE_HOLD_TICKS = 4'd3
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       load_,
   input  logic [3:0] bcd_in,
   input  logic       pgt_clock,
   input  logic       start,
   input  logic       stop,
   input  logic       cancel,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       zero,
   output logic       counting,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, COUNT, PAUSE, DONE} state_t;
   state_t state;

   logic       load_q, tick_q;
   logic [3:0] hold_cnt;
   logic       strobe, tick;
   logic [3:0] d_so, d_st, d_mo, d_mt;
   logic       dec_zero;
   logic [3:0] n_so, n_st, n_mo, n_mt;

   assign strobe = load_q & ~load_;
   assign tick   = ~tick_q & pgt_clock;
   assign zero   = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                   (min_ones == 4'd0) && (min_tens == 4'd0);

   // One-second BCD decrement with borrow ripple.
   always_comb begin
      d_so = sec_ones - 4'd1;
      d_st = sec_tens;
      d_mo = min_ones;
      d_mt = min_tens;
      if (sec_ones == 4'd0) begin
         d_so = 4'd9;
         if (sec_tens == 4'd0) begin
            d_st = SEC_TENS_WRAP;
            if (min_ones == 4'd0) begin
               d_mo = 4'd9;
               d_mt = min_tens - 4'd1;
            end else begin
               d_mo = min_ones - 4'd1;
            end
         end else begin
            d_st = sec_tens - 4'd1;
         end
      end
      dec_zero = ({d_mt, d_mo, d_st, d_so} == 16'h0000);
   end

   // Digits as they enter COUNT.
   always_comb begin
      n_so = sec_ones;
      n_st = sec_tens;
      n_mo = min_ones;
      n_mt = min_tens;
`ifdef COOK_TIMER_NORMALIZE_EN
      if (sec_tens > 4'd5) begin
         if (min_tens == 4'd9 && min_ones == 4'd9) begin
            n_st = 4'd5;
            n_so = 4'd9;
         end else begin
            n_st = sec_tens - 4'd6;
            if (min_ones == 4'd9) begin
               n_mo = 4'd0;
               n_mt = min_tens + 4'd1;
            end else begin
               n_mo = min_ones + 4'd1;
            end
         end
      end
`endif
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state    <= IDLE;
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
         min_ones <= 4'd0;
         min_tens <= 4'd0;
         counting <= 1'b0;
         done     <= 1'b0;
         hold_cnt <= 4'd0;
         load_q   <= 1'b1;
         tick_q   <= 1'b0;
      end else begin
         load_q <= load_;
         tick_q <= pgt_clock;
         case (state)
            IDLE: begin
               if (cancel) begin
                  {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
               end else if (start && !stop && !zero) begin
                  state    <= COUNT;
                  counting <= 1'b1;
                  sec_ones <= n_so;
                  sec_tens <= n_st;
                  min_ones <= n_mo;
                  min_tens <= n_mt;
               end else if (strobe && bcd_in <= 4'd9) begin
                  min_tens <= min_ones;
                  min_ones <= sec_tens;
                  sec_tens <= sec_ones;
                  sec_ones <= bcd_in;
               end
            end
            COUNT: begin
               if (cancel) begin
                  state    <= IDLE;
                  counting <= 1'b0;
                  {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
               end else if (stop) begin
                  state    <= PAUSE;
                  counting <= 1'b0;
               end else if (tick) begin
                  sec_ones <= d_so;
                  sec_tens <= d_st;
                  min_ones <= d_mo;
                  min_tens <= d_mt;
                  if (dec_zero) begin
                     state    <= DONE;
                     counting <= 1'b0;
                     done     <= 1'b1;
                     hold_cnt <= 4'd0;
                  end
               end
            end
            PAUSE: begin
               if (cancel) begin
                  state <= IDLE;
                  {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
               end else if (start && !stop) begin
                  state    <= COUNT;
                  counting <= 1'b1;
               end
            end
            DONE: begin
               if (cancel) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end else if (tick) begin
                  hold_cnt <= hold_cnt + 4'd1;
                  if (hold_cnt + 4'd1 >= DONE_HOLD_TICKS) begin
                     state <= IDLE;
                     done  <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               counting <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule
